// File: rtl/fifo_ctrl_pkg.sv
// Shared types and pointer helpers for the asynchronous FIFO controllers.
// The Gray/binary helpers work on a 32-bit container; callers zero-extend
// their ptr_width+1 pointer on the way in and truncate on the way out, so
// the same functions serve any pointer width up to 32 bits.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_t;

    localparam int PTR_WIDTH_DEFAULT = 8;
    localparam int DEPTH             = 2 ** PTR_WIDTH_DEFAULT;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr_i,
// searching cyclically. Returns one-hot and encoded forms of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               valid_o
);

    // Scan from the priority pointer and keep the first requester found.
    always_comb begin
        int  idx;
        logic found;
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                pick_o[idx] = 1'b1;
                pick_idx_o  = IDX_W'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-domain controller for the asynchronous FIFO: round-robin sharing of
// the single write port with bounded bursts, write pointer ownership and
// full/almost_full generation against the synchronized read pointer.
// Optional feature macro: WR_OVF_CNT_EN (saturating overflow-attempt counter).
//
// state | meaning
// IDLE  | no grant; arbitrate when a request is pending and FIFO not full
// BURST | owner holds the write port until BURST_MAX writes, req drop or full
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int ptr_width    = 8,
    parameter int data_width   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BURST_MAX    = 4,
    parameter int AFULL_THRESH = 4
) (
    input  logic                          wrclk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*data_width-1:0] wdata_in,
    input  logic [ptr_width:0]            rptr_sync,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [ptr_width-1:0]          waddr,
    output logic [data_width-1:0]         wdata,
    output logic [ptr_width:0]            wptr,
    output logic                          full,
    output logic                          almost_full,
    output logic [15:0]                   ovf_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int PW    = ptr_width + 1;
    localparam logic [PW:0] FIFO_DEPTH = {1'b0, 1'b1, {ptr_width{1'b0}}};

    wr_state_t          state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [PW-1:0]      wbin_q, wbin_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic               full_q, full_d;
    logic               afull_q, afull_d;

    logic [NUM_REQ-1:0] arb_pick;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               wr_en_int;
    logic [PW-1:0]      full_target;
    logic [PW-1:0]      rbin;
    logic [PW-1:0]      used;
    logic [PW:0]        free_slots;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i      (req),
        .rr_ptr_i   (rr_q),
        .pick_o     (arb_pick),
        .pick_idx_o (arb_idx),
        .valid_o    (arb_valid)
    );

    assign wr_en_int = (state_q == BURST) && req[owner_q] && !full_q;

    // Next pointer and flags; flags look at the pointer including this cycle's write.
    always_comb begin
        wbin_d      = wbin_q + PW'(wr_en_int);
        wptr_d      = PW'(bin2gray(32'(wbin_d)));
        full_target = {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]};
        full_d      = (wptr_d == full_target);
        rbin        = PW'(gray2bin(32'(rptr_sync)));
        used        = wbin_d - rbin;
        free_slots  = FIFO_DEPTH - {1'b0, used};
        afull_d     = (free_slots <= (PW+1)'(AFULL_THRESH));
    end

    // Grant FSM next state: arbitrate in IDLE, count and terminate bursts in BURST.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_valid && !full_q) begin
                    state_d     = BURST;
                    gnt_d       = arb_pick;
                    owner_d     = arb_idx;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (wr_en_int) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if ((wr_en_int && (burst_cnt_q == CNT_W'(BURST_MAX - 1))) ||
                    !req[owner_q] || full_q) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge wrclk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Write pointer and status flag registers.
    always_ff @(posedge wrclk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

`ifdef WR_OVF_CNT_EN
    logic [15:0] ovf_q;
    logic        ovf_hit;

    assign ovf_hit = full_q && (((state_q == BURST) && req[owner_q]) ||
                                ((state_q == IDLE) && (|req)));

    // Saturating count of write attempts refused because the FIFO is full.
    always_ff @(posedge wrclk or posedge wr_rst) begin
        if (wr_rst) begin
            ovf_q <= '0;
        end else if (ovf_hit && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 16'h0000;
`endif

    assign gnt         = gnt_q;
    assign wr_en       = wr_en_int;
    assign waddr       = wbin_q[ptr_width-1:0];
    assign wdata       = wdata_in[owner_q*data_width +: data_width];
    assign wptr        = wptr_q;
    assign full        = full_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters
// (ptr_width=8, data_width=8, NUM_REQ=4, BURST_MAX=4, AFULL_THRESH=4).
module tb_fifo_wr_arbiter;

    logic        wrclk = 1'b0;
    logic        wr_rst;
    logic [3:0]  req;
    logic [31:0] wdata_in;
    logic [8:0]  rptr_sync;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic [8:0]  wptr;
    logic        full;
    logic        almost_full;
    logic [15:0] ovf_cnt;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_wbin;

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter dut (
        .wrclk       (wrclk),
        .wr_rst      (wr_rst),
        .req         (req),
        .wdata_in    (wdata_in),
        .rptr_sync   (rptr_sync),
        .gnt         (gnt),
        .wr_en       (wr_en),
        .waddr       (waddr),
        .wdata       (wdata),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .ovf_cnt     (ovf_cnt)
    );

    function automatic logic [8:0] gray9(input logic [8:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] slice_val(input int i);
        return 8'hA0 + 8'(8'h11 * i);
    endfunction

    task automatic do_reset();
        wr_rst    = 1'b1;
        req       = 4'b0000;
        rptr_sync = 9'd0;
        @(negedge wrclk);
        @(negedge wrclk);
        wr_rst   = 1'b0;
        exp_wbin = 9'd0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        total++; if (wptr !== 9'd0) begin bad++; $display("FAIL rst_wptr: got %h want 000", wptr); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL rst_flags: got full=%b af=%b want 0 0", full, almost_full); end
        total++; if (ovf_cnt !== 16'd0) begin bad++; $display("FAIL rst_ovf: got %h want 0000", ovf_cnt); end
        // mid-burst asynchronous reset
        req = 4'b0001;
        repeat (3) @(negedge wrclk);
        total++; if (waddr !== 8'd2) begin bad++; $display("FAIL pre_rst_waddr: got %0d want 2", waddr); end
        #2 wr_rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000 || wr_en !== 1'b0) begin bad++; $display("FAIL async_rst_gnt: got gnt=%b wr_en=%b want 0000 0", gnt, wr_en); end
        total++; if (wptr !== 9'd0 || waddr !== 8'd0) begin bad++; $display("FAIL async_rst_ptr: got wptr=%h waddr=%h want 0 0", wptr, waddr); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0 || ovf_cnt !== 16'd0) begin bad++; $display("FAIL async_rst_flags: got %b %b %h want 0 0 0", full, almost_full, ovf_cnt); end
        @(negedge wrclk);
        wr_rst = 1'b0;
        req    = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge wrclk);
            total++; if (wr_en !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL post_rst_idle: got wr_en=%b gnt=%b want 0 0000", wr_en, gnt); end
        end
    endtask

    task automatic test_single_burst();
        logic [8:0] wtbl [4];
        wtbl[0] = 9'h001; wtbl[1] = 9'h003; wtbl[2] = 9'h002; wtbl[3] = 9'h006;
        do_reset();
        req = 4'b0001;
        @(negedge wrclk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sb_gnt: got %b want 0001", gnt); end
        for (int w = 0; w < 4; w++) begin
            total++; if (wr_en !== 1'b1 || waddr !== 8'(w)) begin bad++; $display("FAIL sb_write%0d: got wr_en=%b waddr=%0d want 1 %0d", w, wr_en, waddr, w); end
            @(negedge wrclk);
            total++; if (wptr !== wtbl[w]) begin bad++; $display("FAIL sb_wptr%0d: got %h want %h", w, wptr, wtbl[w]); end
        end
        total++; if (gnt !== 4'b0000 || wr_en !== 1'b0) begin bad++; $display("FAIL sb_bubble: got gnt=%b wr_en=%b want 0000 0", gnt, wr_en); end
        @(negedge wrclk);
        total++; if (gnt !== 4'b0001 || waddr !== 8'd4) begin bad++; $display("FAIL sb_regrant: got gnt=%b waddr=%0d want 0001 4", gnt, waddr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int owner;
        do_reset();
        wdata_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            owner   = g % 4;
            exp_gnt = 4'b0001 << owner;
            @(negedge wrclk);
            total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, exp_gnt); end
            for (int w = 0; w < 4; w++) begin
                total++;
                if (wr_en !== 1'b1 || waddr !== exp_wbin[7:0] || wdata !== slice_val(owner)) begin
                    bad++;
                    $display("FAIL rr_write g%0d w%0d: got wr_en=%b waddr=%0d wdata=%h want 1 %0d %h",
                             g, w, wr_en, waddr, wdata, exp_wbin[7:0], slice_val(owner));
                end
                exp_wbin = exp_wbin + 9'd1;
                @(negedge wrclk);
            end
            total++; if (gnt !== 4'b0000 || wr_en !== 1'b0) begin bad++; $display("FAIL rr_bubble%0d: got gnt=%b wr_en=%b want 0000 0", g, gnt, wr_en); end
        end
    endtask

    task automatic test_full();
        int cnt = 0;
        int cyc = 0;
        logic [15:0] exp_ovf;
        do_reset();
        req = 4'b0001;
        while (cnt < 256 && cyc < 1000) begin
            @(negedge wrclk);
            cyc++;
            if (wr_en === 1'b1) cnt++;
        end
        total++; if (cnt != 256) begin bad++; $display("FAIL full_fill: got %0d writes want 256 within budget", cnt); end
        @(negedge wrclk);
        total++; if (full !== 1'b1 || wptr !== 9'h180) begin bad++; $display("FAIL full_set: got full=%b wptr=%h want 1 180", full, wptr); end
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL full_af: got %b want 1", almost_full); end
        for (int c = 0; c < 5; c++) begin
            total++; if (wr_en !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL full_block%0d: got wr_en=%b gnt=%b want 0 0000", c, wr_en, gnt); end
            @(negedge wrclk);
        end
`ifdef WR_OVF_CNT_EN
        exp_ovf = 16'd5;
`else
        exp_ovf = 16'd0;
`endif
        total++; if (ovf_cnt !== exp_ovf) begin bad++; $display("FAIL full_ovf: got %0d want %0d", ovf_cnt, exp_ovf); end
        rptr_sync = gray9(9'd1);
        @(negedge wrclk);
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0", full); end
        @(negedge wrclk);
        total++; if (wr_en !== 1'b1 || waddr !== 8'd0) begin bad++; $display("FAIL full_extra_write: got wr_en=%b waddr=%0d want 1 0", wr_en, waddr); end
        @(negedge wrclk);
        total++; if (full !== 1'b1 || wr_en !== 1'b0 || wptr !== 9'h181) begin bad++; $display("FAIL full_again: got full=%b wr_en=%b wptr=%h want 1 0 181", full, wr_en, wptr); end
    endtask

    task automatic test_afull_wrap();
        int writes = 0;
        int e = 0;
        int lag;
        int w;
        logic exp_af;
        do_reset();
        req = 4'b0001;
        while (writes < 600 && e < 1000) begin
            e++;
            lag = 248 + (e % 7);
            rptr_sync = gray9(exp_wbin - 9'(lag));
            w = ((e >= 2) && (((e - 2) % 5) < 4)) ? 1 : 0;
            if (w == 1) begin
                exp_wbin = exp_wbin + 9'd1;
                writes++;
            end
            exp_af = ((lag + w) >= 252);
            @(negedge wrclk);
            total++; if (almost_full !== exp_af) begin bad++; $display("FAIL af_cycle%0d: got %b want %b (used=%0d)", e, almost_full, exp_af, lag + w); end
            total++; if (full !== 1'b0) begin bad++; $display("FAIL af_nofull%0d: got %b want 0", e, full); end
            total++; if (wptr !== gray9(exp_wbin)) begin bad++; $display("FAIL af_wptr%0d: got %h want %h", e, wptr, gray9(exp_wbin)); end
        end
        total++; if (writes != 600) begin bad++; $display("FAIL af_budget: got %0d writes want 600", writes); end
    endtask

    task automatic test_early_drop();
        do_reset();
        wdata_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b0011;
        @(negedge wrclk);
        total++; if (gnt !== 4'b0001 || waddr !== 8'd0 || wr_en !== 1'b1) begin bad++; $display("FAIL ed_first: got gnt=%b waddr=%0d wr_en=%b want 0001 0 1", gnt, waddr, wr_en); end
        @(negedge wrclk);
        total++; if (waddr !== 8'd1 || wr_en !== 1'b1) begin bad++; $display("FAIL ed_second: got waddr=%0d wr_en=%b want 1 1", waddr, wr_en); end
        @(negedge wrclk);
        req = 4'b0010;
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL ed_drop: got wr_en=%b want 0", wr_en); end
        @(negedge wrclk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ed_exit: got gnt=%b want 0000", gnt); end
        @(negedge wrclk);
        total++; if (gnt !== 4'b0010 || wr_en !== 1'b1 || waddr !== 8'd2 || wdata !== 8'hB1) begin
            bad++;
            $display("FAIL ed_next: got gnt=%b wr_en=%b waddr=%0d wdata=%h want 0010 1 2 b1", gnt, wr_en, waddr, wdata);
        end
    endtask

    initial begin
        wr_rst    = 1'b1;
        req       = 4'b0000;
        rptr_sync = 9'd0;
        wdata_in  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        exp_wbin  = 9'd0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full();
        test_afull_wrap();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
